mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Multicycle memory initiator for the MIPS datapath. It accepts fetch, load and store requests from the control unit, sequences them onto the single-port memory-system interface (address, write enable, write data in; read data out), and latches the results into the instruction register and memory data register. It also enforces the ROM/RAM address split: stores into the ROM region are refused and flagged.

## Interface
- DATA_WIDTH, 32, width of address and data buses.
- READ_LATENCY, 1, cycles the address is held before read data is sampled (legal 1..7).
- ROM_LIMIT, 32'h1000_0000, addresses below this are ROM (read-only); at or above are RAM.

- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_i  in  1  request strobe, sampled only in IDLE.
- op_i  in  2  00 fetch, 01 load, 10 store, 11 reserved.
- addr_i  in  DATA_WIDTH  byte address of request.
- wdata_i  in  DATA_WIDTH  store data.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  one-cycle pulse coincident with done_o on a rejected request.
- instr_o  out  DATA_WIDTH  instruction register.
- mdr_o  out  DATA_WIDTH  memory data register.
- Address_o  out  DATA_WIDTH  registered address to memory system.
- Write_Enable_o  out  1  registered write strobe to memory system.
- Write_Data_o  out  DATA_WIDTH  registered write data to memory system.
- Read_Data_i  in  DATA_WIDTH  read data from memory system.

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE: if req_i, latch op, address, wdata. A valid request goes to ACCESS. A rejected request goes to DONE with the error flag set.
- Rejection rules: op 11; store with address < ROM_LIMIT; misalignment (see Configuration).
- ACCESS, read (fetch/load): Address_o is held and a 3-bit counter runs from READ_LATENCY-1 down to 0. At 0, Read_Data_i is captured into instr_o (fetch) or mdr_o (load), then the unit goes to DONE.
- ACCESS, store: Write_Enable_o is high for exactly this one cycle, with Address_o/Write_Data_o valid, then the unit goes to DONE.
- DONE: done_o=1 and err_o=flag for one cycle, then the unit returns to IDLE.
- req_i outside IDLE is ignored; there is no queuing.
- instr_o and mdr_o change only on a successful capture of their own op; a rejected request leaves both unchanged.
- Reset (any state, asynchronous): state IDLE. All outputs 0, including instr_o, mdr_o, Address_o, Write_Data_o, Write_Enable_o, busy_o, done_o, err_o. An in-flight store aborted by reset must not leave Write_Enable_o high past the reset assertion.

## Timing
- Request sampled at edge ending cycle N.
- Read: Address_o valid cycles N+1..N+READ_LATENCY. Capture occurs at the edge ending N+READ_LATENCY. done_o is high in N+READ_LATENCY+1. The next request is accepted from N+READ_LATENCY+2.
- Store: Write_Enable_o is high in N+1 only; done_o in N+2.
- Rejected: done_o=err_o=1 in N+1; no memory activity (Write_Enable_o stays 0, Address_o unchanged).
- Address boundary: ROM_LIMIT-4 is ROM; ROM_LIMIT is RAM (unsigned compare, full width).

## Configuration
- MISALIGN_CHECK_EN defined: fetch/load/store with addr_i[1:0]≠0 are rejected (err_o), with no memory access.
- MISALIGN_CHECK_EN undefined: no misalignment error; addr_i[1:0] is forced to 00 on Address_o and the access proceeds.

## Test plan
- Reset mid-read: assert reset during ACCESS with READ_LATENCY=3 -> all outputs 0 immediately, state IDLE. The first request after release completes normally.
- Fetch at 0x0040_0000 with READ_LATENCY=2, memory returning 0x2008_0005 -> instr_o=0x2008_0005 after the capture edge; done_o high 3 cycles after request; mdr_o unchanged.
- Store 0xDEAD_BEEF to 0x1001_0004, then load same address -> Write_Enable_o high exactly one cycle; load yields mdr_o=0xDEAD_BEEF.
- Store to 0x0FFF_FFFC -> done_o=err_o=1 next cycle, Write_Enable_o never asserted. Store to 0x1000_0000 succeeds.
- Load at 0x1001_0002: with MISALIGN_CHECK_EN -> err_o=1, no access; without it -> Address_o=0x1001_0000 and the load completes.
- req_i held high continuously with op 01 -> back-to-back loads spaced READ_LATENCY+2 cycles apart; busy_o low only in the accept cycles.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: multicycle memory initiator for the MIPS datapath.
// Sequences fetch, load and store requests onto a single-port memory
// interface. Read results are latched into the instruction register or the
// memory data register. Stores into the ROM region are refused and flagged.
// Optional build macro MISALIGN_CHECK_EN: when defined, requests whose
// addr_i[1:0] is non-zero are rejected. When undefined, those low address
// bits are forced to 00 on Address_o and the access proceeds.
module mem_access_unit #(
  parameter int unsigned               DATA_WIDTH   = 32,
  parameter int unsigned               READ_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0]     ROM_LIMIT    = 32'h1000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_i,
  input  logic [1:0]            op_i,
  input  logic [DATA_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [DATA_WIDTH-1:0] mdr_o,
  output logic [DATA_WIDTH-1:0] Address_o,
  output logic                  Write_Enable_o,
  output logic [DATA_WIDTH-1:0] Write_Data_o,
  input  logic [DATA_WIDTH-1:0] Read_Data_i
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  localparam logic [1:0] OP_FETCH = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  localparam logic [2:0] CNT_INIT = 3'(READ_LATENCY - 1);

  logic [1:0]            state;
  logic [1:0]            op_q;
  logic [2:0]            cnt;
  logic                  err_flag;
  logic                  misalign_err;
  logic                  reject;
  logic [DATA_WIDTH-1:0] access_addr;

`ifdef MISALIGN_CHECK_EN
  assign misalign_err = |addr_i[1:0];
  assign access_addr  = addr_i;
`else
  assign misalign_err = 1'b0;
  assign access_addr  = {addr_i[DATA_WIDTH-1:2], 2'b00};
`endif

  // Classify the incoming request: reserved op, ROM store, or misalignment.
  always_comb begin
    reject = 1'b0;
    if (op_i == OP_RSVD)                          reject = 1'b1;
    if ((op_i == OP_STORE) && (addr_i < ROM_LIMIT)) reject = 1'b1;
    if (misalign_err)                             reject = 1'b1;
  end

  assign busy_o = (state != IDLE);
  assign done_o = (state == DONE);
  assign err_o  = (state == DONE) && err_flag;

  // Request sequencer. The memory-side outputs and result registers are
  // updated only by successful accesses, so a rejected request leaves them
  // untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      op_q           <= OP_FETCH;
      cnt            <= '0;
      err_flag       <= 1'b0;
      instr_o        <= '0;
      mdr_o          <= '0;
      Address_o      <= '0;
      Write_Enable_o <= 1'b0;
      Write_Data_o   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_i) begin
            op_q <= op_i;
            if (reject) begin
              err_flag <= 1'b1;
              state    <= DONE;
            end else begin
              err_flag  <= 1'b0;
              Address_o <= access_addr;
              cnt       <= CNT_INIT;
              state     <= ACCESS;
              if (op_i == OP_STORE) begin
                Write_Enable_o <= 1'b1;
                Write_Data_o   <= wdata_i;
              end
            end
          end
        end
        ACCESS: begin
          if (op_q == OP_STORE) begin
            Write_Enable_o <= 1'b0;
            state          <= DONE;
          end else if (cnt == 3'd0) begin
            if (op_q == OP_FETCH) instr_o <= Read_Data_i;
            else                  mdr_o   <= Read_Data_i;
            state <= DONE;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed self-checking bench for mem_access_unit.
// A small word memory answers reads combinationally from Address_o and
// commits writes on clock edges where Write_Enable_o is high.
// Honours MISALIGN_CHECK_EN the same way the design does.
module tb_mem_access_unit;

  localparam int unsigned RL = 3;
  localparam int unsigned P  = RL + 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        busy, done, err, we;
  logic [31:0] instr, mdr, mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [0:63];
  int unsigned we_count = 0;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  mem_access_unit #(
    .DATA_WIDTH  (32),
    .READ_LATENCY(RL),
    .ROM_LIMIT   (32'h1000_0000)
  ) u_dut (
    .clk           (clk),
    .reset         (reset),
    .req_i         (req),
    .op_i          (op),
    .addr_i        (addr),
    .wdata_i       (wdata),
    .busy_o        (busy),
    .done_o        (done),
    .err_o         (err),
    .instr_o       (instr),
    .mdr_o         (mdr),
    .Address_o     (mem_addr),
    .Write_Enable_o(we),
    .Write_Data_o  (mem_wdata),
    .Read_Data_i   (mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: the fetch address holds a fixed instruction word.
  assign mem_rdata = (mem_addr == 32'h0040_0000) ? 32'h2008_0005 : mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (we) begin
      mem[mem_addr[7:2]] <= mem_wdata;
      we_count           <= we_count + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one cycle; returns positioned in cycle N+1.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] d);
    req   = 1'b1;
    op    = o;
    addr  = a;
    wdata = d;
    tick();
    req   = 1'b0;
  endtask

  // Count cycles from N+1 until done is seen, bounded.
  task automatic wait_done(output int unsigned cyc);
    cyc = 1;
    while (!done && cyc < 20) begin
      tick();
      cyc++;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_busy"},  {31'd0, busy},  32'd0);
    check_eq({tag, "_done"},  {31'd0, done},  32'd0);
    check_eq({tag, "_err"},   {31'd0, err},   32'd0);
    check_eq({tag, "_instr"}, instr,          32'd0);
    check_eq({tag, "_mdr"},   mdr,            32'd0);
    check_eq({tag, "_addr"},  mem_addr,       32'd0);
    check_eq({tag, "_we"},    {31'd0, we},    32'd0);
    check_eq({tag, "_wdata"}, mem_wdata,      32'd0);
  endtask

  initial begin
    int unsigned cyc;
    int unsigned w0;
    int unsigned busy_low;
    int unsigned first_done;
    int unsigned last_done;
    int unsigned n_done;

    // Reset state
    tick();
    tick();
    check_all_zero("reset");
    reset = 1'b1;
    tick();

    // Fetch
    issue(2'b00, 32'h0040_0000, 32'h0);
    check_eq("fetch_busy", {31'd0, busy}, 32'd1);
    check_eq("fetch_addr", mem_addr, 32'h0040_0000);
    wait_done(cyc);
    check_eq("fetch_latency", cyc, RL + 1);
    check_eq("fetch_err", {31'd0, err}, 32'd0);
    check_eq("fetch_instr", instr, 32'h2008_0005);
    check_eq("fetch_mdr", mdr, 32'd0);
    tick();
    check_eq("fetch_idle", {31'd0, busy}, 32'd0);

    // Store to RAM, then load it back
    w0 = we_count;
    issue(2'b10, 32'h1001_0004, 32'hDEAD_BEEF);
    check_eq("st_we", {31'd0, we}, 32'd1);
    check_eq("st_addr", mem_addr, 32'h1001_0004);
    check_eq("st_wdata", mem_wdata, 32'hDEAD_BEEF);
    wait_done(cyc);
    check_eq("st_latency", cyc, 32'd2);
    check_eq("st_we_off", {31'd0, we}, 32'd0);
    check_eq("st_err", {31'd0, err}, 32'd0);
    check_eq("st_we_cycles", we_count - w0, 32'd1);
    tick();

    issue(2'b01, 32'h1001_0004, 32'h0);
    wait_done(cyc);
    check_eq("ld_latency", cyc, RL + 1);
    check_eq("ld_mdr", mdr, 32'hDEAD_BEEF);
    check_eq("ld_instr", instr, 32'h2008_0005);
    tick();

    // Store at the last ROM word is refused
    w0 = we_count;
    issue(2'b10, 32'h0FFF_FFFC, 32'h5555_5555);
    check_eq("rom_done", {31'd0, done}, 32'd1);
    check_eq("rom_err", {31'd0, err}, 32'd1);
    check_eq("rom_we", {31'd0, we}, 32'd0);
    check_eq("rom_addr", mem_addr, 32'h1001_0004);
    tick();
    check_eq("rom_idle", {31'd0, busy}, 32'd0);
    check_eq("rom_we_cycles", we_count - w0, 32'd0);

    // Store at the first RAM word succeeds
    w0 = we_count;
    issue(2'b10, 32'h1000_0000, 32'h1234_5678);
    check_eq("ram_we", {31'd0, we}, 32'd1);
    wait_done(cyc);
    check_eq("ram_latency", cyc, 32'd2);
    check_eq("ram_err", {31'd0, err}, 32'd0);
    check_eq("ram_we_cycles", we_count - w0, 32'd1);
    tick();

    // Reserved op
    issue(2'b11, 32'h1001_0000, 32'h0);
    check_eq("rsvd_done", {31'd0, done}, 32'd1);
    check_eq("rsvd_err", {31'd0, err}, 32'd1);
    check_eq("rsvd_mdr", mdr, 32'hDEAD_BEEF);
    tick();

    // Misaligned load
    issue(2'b01, 32'h1001_0002, 32'h0);
`ifdef MISALIGN_CHECK_EN
    check_eq("mis_done", {31'd0, done}, 32'd1);
    check_eq("mis_err", {31'd0, err}, 32'd1);
    check_eq("mis_addr", mem_addr, 32'h1000_0000);
    check_eq("mis_mdr", mdr, 32'hDEAD_BEEF);
`else
    check_eq("mis_addr", mem_addr, 32'h1001_0000);
    wait_done(cyc);
    check_eq("mis_latency", cyc, RL + 1);
    check_eq("mis_err", {31'd0, err}, 32'd0);
    check_eq("mis_mdr", mdr, 32'h1234_5678);
`endif
    tick();

    // Back-to-back loads with req held high
    req  = 1'b1;
    op   = 2'b01;
    addr = 32'h1001_0004;
    busy_low = 0; n_done = 0; first_done = 0; last_done = 0;
    for (int unsigned i = 0; i < 3 * P; i++) begin
      if (!busy) busy_low++;
      if (done) begin
        if (n_done == 0) first_done = i;
        else check_eq("b2b_spacing", i - last_done, P);
        last_done = i;
        n_done++;
      end
      tick();
    end
    req = 1'b0;
    check_eq("b2b_busy_low", busy_low, 32'd3);
    check_eq("b2b_n_done", n_done, 32'd3);
    check_eq("b2b_first_done", first_done, RL + 1);
    check_eq("b2b_mdr", mdr, 32'hDEAD_BEEF);
    check_eq("b2b_idle", {31'd0, busy}, 32'd0);

    // Reset in the middle of a read
    issue(2'b00, 32'h0040_0000, 32'h0);
    tick();
    check_eq("rst_rd_busy_pre", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    check_all_zero("rst_rd");
    tick();
    reset = 1'b1;

    // Reset while a store is driving Write_Enable_o
    w0 = we_count;
    issue(2'b10, 32'h1001_0008, 32'hAAAA_AAAA);
    check_eq("rst_st_we_pre", {31'd0, we}, 32'd1);
    reset = 1'b0;
    #1;
    check_eq("rst_st_we", {31'd0, we}, 32'd0);
    tick();
    check_eq("rst_st_we_cycles", we_count - w0, 32'd0);
    reset = 1'b1;
    tick();

    // First request after reset completes normally
    issue(2'b00, 32'h0040_0000, 32'h0);
    wait_done(cyc);
    check_eq("post_rst_latency", cyc, RL + 1);
    check_eq("post_rst_instr", instr, 32'h2008_0005);
    check_eq("post_rst_mdr", mdr, 32'd0);
    tick();
    check_eq("post_rst_idle", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
